// File: rtl/seq_mult_controller.sv
// seq_mult_controller: LSB-first shift/add sequencer driving the right-shift stage of a shift-add multiplier
module seq_mult_controller #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [WIDTH-1:0]         multiplier,
   input  logic                     shift_done,
   output logic                     ready,
   output logic                     load,
   output logic                     shift,
   output logic                     add_shift,
   output logic [$clog2(WIDTH)-1:0] iter,
   output logic                     done,
   output logic                     error
);
   localparam int IW = $clog2(WIDTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);
   localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] mreg;
   logic [TW-1:0]    tcnt;
   // state machine; every output is registered and set on the transition into the state that owns it
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mreg      <= '0;
         iter      <= '0;
         tcnt      <= '0;
         ready     <= 1'b1;
         load      <= 1'b0;
         shift     <= 1'b0;
         add_shift <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         ready     <= 1'b0;
         load      <= 1'b0;
         shift     <= 1'b0;
         add_shift <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mreg  <= multiplier;
                  iter  <= '0;
                  error <= 1'b0;
                  load  <= 1'b1;
                  state <= LOAD;
               end else begin
                  ready <= 1'b1;
               end
            end
            LOAD: begin
               add_shift <= mreg[0];
               shift     <= ~mreg[0];
               state     <= ISSUE;
            end
            ISSUE: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (shift_done) begin
                  mreg <= mreg >> 1;
                  if (iter == LAST_ITER) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     iter      <= iter + 1'b1;
                     add_shift <= mreg[1];
                     shift     <= ~mreg[1];
                     state     <= ISSUE;
                  end
               end else if (tcnt == LAST_WAIT) begin
                  error <= 1'b1;
                  ready <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mult_controller.sv
// tb_seq_mult_controller: directed checks of strobe order, timing, timeout, reset abort and protocol robustness
module tb_seq_mult_controller;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        shift_done = 1'b0;
   logic [15:0] multiplier = '0;
   logic        ready, load, shift, add_shift, done, error;
   logic [3:0]  iter;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;

   seq_mult_controller #(.WIDTH(16), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .start(start), .multiplier(multiplier),
      .shift_done(shift_done), .ready(ready), .load(load), .shift(shift),
      .add_shift(add_shift), .iter(iter), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // the two strobes must never be high together
   always @(negedge clk) begin
      n_chk++;
      assert (!(shift && add_shift)) else begin
         n_fail++;
         $error("FAIL excl: shift=%b add_shift=%b, expected not both high", shift, add_shift);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input logic [15:0] m, input int slow_k, input int stall_k, input bit noisy);
      int exp_cyc, n_add, n_shf, d;
      n_add = 0;
      n_shf = 0;
      step();
      multiplier = m;
      start = 1'b1;
      cyc = 0;
      chk("idle_ready", 32'(ready), 1);
      step();
      start = 1'b0;
      chk("load", 32'(load), 1);
      chk("busy_ready", 32'(ready), 0);
      chk("err_clr", 32'(error), 0);
      exp_cyc = 2;
      for (int k = 0; k < 16; k++) begin
         while (!(shift || add_shift) && cyc < exp_cyc + 4) begin
            step();
            shift_done = 1'b0;
            start = noisy & cyc[0];
         end
         chk("strobe_cyc", 32'(cyc), 32'(exp_cyc));
         chk("iter", 32'(iter), 32'(k));
         chk("add_shift", 32'(add_shift), 32'(m[k]));
         chk("shift", 32'(shift), 32'(!m[k]));
         n_add += int'(add_shift);
         n_shf += int'(shift);
         if (noisy) shift_done = 1'b1;
         if (k == stall_k) begin
            for (int j = 1; j <= 9; j++) begin
               step();
               chk("to_error", 32'(error), 32'(j == 9));
               chk("to_ready", 32'(ready), 32'(j == 9));
               chk("to_nodone", 32'(done), 0);
            end
            return;
         end
         d = (k == slow_k) ? 3 : 1;
         for (int j = 1; j <= d; j++) begin
            step();
            shift_done = (j == d);
            start = noisy;
            chk("no_strobe", 32'(shift | add_shift), 0);
         end
         exp_cyc += 1 + d;
      end
      while (!done && cyc < exp_cyc + 4) begin
         step();
         shift_done = 1'b0;
         start = 1'b0;
      end
      chk("done_cyc", 32'(cyc), 32'(exp_cyc));
      chk("done_iter", 32'(iter), 15);
      chk("done_err", 32'(error), 0);
      chk("n_add", 32'(n_add), 32'($countones(m)));
      chk("n_shift", 32'(n_shf), 32'(16 - $countones(m)));
      step();
      chk("post_ready", 32'(ready), 1);
      chk("done_once", 32'(done), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_load", 32'(load), 0);
      chk("rst_strobe", 32'(shift | add_shift), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_iter", 32'(iter), 0);
      reset = 1'b0;
      shift_done = 1'b1;
      step();
      step();
      shift_done = 1'b0;
      chk("idle_sd_iter", 32'(iter), 0);
      chk("idle_sd_ready", 32'(ready), 1);
      chk("idle_sd_strobe", 32'(shift | add_shift), 0);
      run(16'hA5A5, -1, -1, 1'b0);
      run(16'h0000, -1, -1, 1'b0);
      run(16'hFFFF, -1, -1, 1'b0);
      run(16'h3C96, 5, -1, 1'b0);
      run(16'h1234, -1, 2, 1'b0);
      repeat (3) step();
      chk("err_sticky", 32'(error), 1);
      chk("err_nodone", 32'(done), 0);
      run(16'h8001, -1, -1, 1'b1);
      step();
      multiplier = 16'hFFFF;
      start = 1'b1;
      shift_done = 1'b1;
      cyc = 0;
      step();
      start = 1'b0;
      while (cyc < 10) step();
      reset = 1'b1;
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      chk("rr_ready", 32'(ready), 1);
      chk("rr_iter", 32'(iter), 0);
      chk("rr_load", 32'(load), 0);
      chk("rr_strobe", 32'(shift | add_shift), 0);
      chk("rr_done", 32'(done), 0);
      for (int j = 0; j < 4; j++) begin
         step();
         chk("rr_quiet", 32'(shift | add_shift | done), 0);
         chk("rr_idle", 32'(ready), 1);
      end
      shift_done = 1'b0;
      run(16'h0001, -1, -1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
